// File: rtl/isa_fetch_if.sv
// isa_fetch_if: DRAM read and CCU instruction channels of the ISA fetch stage.
// master = fetch stage: drives the read request, read-data ready and the CCU word channel.
// slave  = environment: drives request ready, read beats and CCU ready.
interface isa_fetch_if #(
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH       = 16
);
    logic                       ITFDRAM_RdReqVld;
    logic                       DRAMITF_RdReqRdy;
    logic [DRAM_ADDR_WIDTH-1:0] ITFDRAM_RdAddr;
    logic [LEN_WIDTH-1:0]       ITFDRAM_RdLen;
    logic                       DRAMITF_RdDatVld;
    logic [PORT_WIDTH-1:0]      DRAMITF_RdDat;
    logic                       ITFDRAM_RdDatRdy;
    logic [PORT_WIDTH-1:0]      ITFCCU_ISARdDat;
    logic                       ITFCCU_ISARdDatVld;
    logic                       ITFCCU_ISARdDatLast;
    logic                       CCUITF_ISARdDatRdy;
    modport master (
        output ITFDRAM_RdReqVld, ITFDRAM_RdAddr, ITFDRAM_RdLen, ITFDRAM_RdDatRdy,
        output ITFCCU_ISARdDat, ITFCCU_ISARdDatVld, ITFCCU_ISARdDatLast,
        input  DRAMITF_RdReqRdy, DRAMITF_RdDatVld, DRAMITF_RdDat, CCUITF_ISARdDatRdy
    );
    modport slave (
        input  ITFDRAM_RdReqVld, ITFDRAM_RdAddr, ITFDRAM_RdLen, ITFDRAM_RdDatRdy,
        input  ITFCCU_ISARdDat, ITFCCU_ISARdDatVld, ITFCCU_ISARdDatLast,
        output DRAMITF_RdReqRdy, DRAMITF_RdDatVld, DRAMITF_RdDat, CCUITF_ISARdDatRdy
    );
endinterface

// File: rtl/isa_fetch.sv
// isa_fetch: fetches a program of ISA words from DRAM in credit-gated bursts and streams them to the CCU.
// Ports: clk/rst (async active-high), start/base_addr/total_words launch a program,
// busy/done report progress, bus carries the DRAM read and CCU word channels.
module isa_fetch #(
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int BURST_LEN       = 16,
    parameter int FIFO_ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]       total_words,
    output logic                       busy,
    output logic                       done,
    isa_fetch_if.master                bus
);
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [LEN_WIDTH-1:0] BURST = LEN_WIDTH'(BURST_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
    localparam logic [FIFO_ADDR_WIDTH:0] PTR_ONE = (FIFO_ADDR_WIDTH+1)'(1);
    localparam logic [DRAM_ADDR_WIDTH-1:0] BEAT_BYTES = DRAM_ADDR_WIDTH'(PORT_WIDTH / 8);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t                     state_q;
    logic [DRAM_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]       remaining_q, total_q, sent_q, reserved_q, sent_d, reserved_d, len;
    logic [FIFO_ADDR_WIDTH:0]   wptr_q, rptr_q;
    logic [PORT_WIDTH-1:0]      mem_q [DEPTH];
    logic                       busy_q, done_q;
    logic                       fifo_empty, fifo_full, push, pop, req_vld, req_hs, is_last;
    always_comb begin
        fifo_empty = wptr_q == rptr_q;
        fifo_full  = wptr_q == {~rptr_q[FIFO_ADDR_WIDTH], rptr_q[FIFO_ADDR_WIDTH-1:0]};
        len        = remaining_q < BURST ? remaining_q : BURST;
        // reserved counts every word that may still land in the FIFO, so a granted burst always fits
        req_vld    = state_q == REQ && ({1'b0, reserved_q} + {1'b0, len}) <= (LEN_WIDTH+1)'(DEPTH);
        req_hs     = req_vld & bus.DRAMITF_RdReqRdy;
        push       = bus.DRAMITF_RdDatVld & ~fifo_full;
        pop        = ~fifo_empty & bus.CCUITF_ISARdDatRdy;
        is_last    = sent_q == total_q - ONE;
        sent_d     = sent_q + LEN_WIDTH'(pop);
        reserved_d = reserved_q + (req_hs ? len : '0) - LEN_WIDTH'(pop);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            total_q     <= '0;
            sent_q      <= '0;
            reserved_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            wptr_q     <= push ? wptr_q + PTR_ONE : wptr_q;
            rptr_q     <= pop ? rptr_q + PTR_ONE : rptr_q;
            sent_q     <= sent_d;
            reserved_q <= reserved_d;
            case (state_q)
                IDLE: if (start) begin
                    if (total_words != '0) begin
                        addr_q      <= base_addr;
                        remaining_q <= total_words;
                        total_q     <= total_words;
                        sent_q      <= '0;
                        reserved_q  <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= REQ;
                    end else done_q <= 1'b1;
                end
                REQ: if (req_hs) begin
                    addr_q      <= addr_q + DRAM_ADDR_WIDTH'(len) * BEAT_BYTES;
                    remaining_q <= remaining_q - len;
                    state_q     <= remaining_q == len ? DRAIN : REQ;
                end
                DRAIN: if (pop && is_last) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    always_ff @(posedge clk)
        if (push) mem_q[wptr_q[FIFO_ADDR_WIDTH-1:0]] <= bus.DRAMITF_RdDat;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign bus.ITFDRAM_RdReqVld    = req_vld;
    assign bus.ITFDRAM_RdAddr      = addr_q;
    assign bus.ITFDRAM_RdLen       = len;
    assign bus.ITFDRAM_RdDatRdy    = ~fifo_full;
    assign bus.ITFCCU_ISARdDat     = fifo_empty ? '0 : mem_q[rptr_q[FIFO_ADDR_WIDTH-1:0]];
    assign bus.ITFCCU_ISARdDatVld  = ~fifo_empty;
    assign bus.ITFCCU_ISARdDatLast = ~fifo_empty & is_last;
endmodule

// File: doc/isa_fetch.md
# isa_fetch

ISA fetch stage feeding the CCU instruction port. On a start pulse it reads a program of `total_words` ISA words (PORT_WIDTH bits each) from DRAM through burst read requests, buffers the words in a local FIFO, and streams them to the CCU on the `ITFCCU_ISARdDat*` valid/ready channel. The final word is flagged with `Last`. Requests are credit-gated so that returned read data can always be accepted.

## Interface
- PORT_WIDTH, 128, ISA word / DRAM beat width in bits
- DRAM_ADDR_WIDTH, 32, byte address width
- LEN_WIDTH, 16, width of word counts
- BURST_LEN, 16, maximum words per read request
- FIFO_ADDR_WIDTH, 5, FIFO depth = 2^FIFO_ADDR_WIDTH; must satisfy depth ≥ BURST_LEN

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle launch pulse; ignored while busy
- base_addr  in  DRAM_ADDR_WIDTH  byte address of the first word; sampled on an accepted start
- total_words  in  LEN_WIDTH  program length in words; sampled on an accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at program completion
- ITFDRAM_RdReqVld  out  1  read request valid
- DRAMITF_RdReqRdy  in  1  read request ready
- ITFDRAM_RdAddr  out  DRAM_ADDR_WIDTH  request byte address
- ITFDRAM_RdLen  out  LEN_WIDTH  request length in words
- DRAMITF_RdDatVld  in  1  read beat valid
- DRAMITF_RdDat  in  PORT_WIDTH  read beat data
- ITFDRAM_RdDatRdy  out  1  `!fifo_full`
- ITFCCU_ISARdDat  out  PORT_WIDTH  FIFO head word
- ITFCCU_ISARdDatVld  out  1  `!fifo_empty`
- ITFCCU_ISARdDatLast  out  1  head word is word `total_words-1`
- CCUITF_ISARdDatRdy  in  1  CCU accepts the head word

## Operation
- FSM states: IDLE, REQ, DRAIN.
- IDLE, start with total_words ≠ 0:
  - Latch `addr=base_addr`, `remaining=total_words`, `total=total_words`.
  - Clear `sent` and `reserved`; go to REQ.
- IDLE, start with total_words = 0: pulse done the next cycle; stay IDLE; busy stays 0.
- REQ:
  - `len = min(BURST_LEN, remaining)`.
  - Assert RdReqVld only when `depth − reserved ≥ len`. `reserved` = words requested but not yet popped to the CCU.
  - Addr/Len must stay stable while Vld is high and Rdy is low.
  - On handshake: `addr += len*PORT_WIDTH/8`, `remaining −= len`, `reserved += len`.
  - If `remaining` reaches 0, go to DRAIN; otherwise stay in REQ.
- Data side (all states):
  - Push on `DRAMITF_RdDatVld & !fifo_full`.
  - Pop on `ITFCCU_ISARdDatVld & CCUITF_ISARdDatRdy`.
  - Each pop: `sent += 1`, `reserved −= 1`.
  - On a simultaneous request handshake and pop, update `reserved` by `len − 1`.
- Last = `ITFCCU_ISARdDatVld & (sent == total−1)`.
- DRAIN: when the pop of word `total−1` happens, go to IDLE and pulse done in that same transition cycle. FIFO is empty afterwards.
- Beats arriving while IDLE (protocol violation) are still pushed. No other checking.
- Address arithmetic wraps modulo 2^DRAM_ADDR_WIDTH. Counts are LEN_WIDTH bits and never exceed total.

## Timing
- Reset values:
  - State IDLE, FIFO empty, counters 0.
  - busy=0, done=0, RdReqVld=0, RdAddr=0, RdLen=0.
  - RdDatRdy=1, ISARdDatVld=0, Last=0, ISARdDat=0.
- Start accepted at cycle t: busy=1 and RdReqVld=1 at t+1 (credit is always sufficient on the first request).
- FIFO is first-word-fall-through with a registered write: a beat pushed at cycle t is visible on ITFCCU at t+1. With an empty FIFO, push and pop cannot occur in the same cycle.
- Next request may issue the cycle after a handshake if credit allows. Throughput is 1 word/cycle with no backpressure.
- done is asserted in the cycle after the final pop handshake; busy falls in that same cycle.
- A start arriving in the done cycle is accepted (state is IDLE).
- rst mid-operation: immediate return to reset values, and FIFO contents are discarded. The bench must also reset the DRAM model.

## Test plan
- total_words=1, base 0x1000, zero-latency DRAM, CCU always ready -> one request (0x1000, len 1); word out with Vld=Last=1; done two cycles after the beat arrives.
- total_words=40, BURST_LEN=16, depth 32, base 0x0 -> requests (0x000,16), (0x100,16), (0x200,8). The third request waits until ≥8 words have been popped. Last only on word 39; data order preserved.
- Same 40-word run, CCU ready toggling 1-of-3 cycles -> no FIFO overflow, RdDatRdy never low, `reserved ≤ 32` at all times, all 40 words in order.
- DRAMITF_RdReqRdy held low 5 cycles -> RdReqVld/Addr/Len stable throughout; a start pulse issued during busy is ignored.
- total_words=0 -> no request, busy stays 0, done pulses once at t+1.
- rst asserted after 10 of 40 words -> all outputs at reset values in the same cycle. A new start (8 words) after release runs cleanly with no stale data.
